// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception type codes and field masks.
package cp0_reg_pkg;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14
    } cp0_reg_e;

    typedef enum logic [31:0] {
        EXC_NONE = 32'h0000_0000,
        EXC_INT  = 32'h0000_0001,
        EXC_ADEL = 32'h0000_0004,
        EXC_ADES = 32'h0000_0005,
        EXC_SYS  = 32'h0000_0008,
        EXC_BP   = 32'h0000_0009,
        EXC_RI   = 32'h0000_000a,
        EXC_OV   = 32'h0000_000c,
        EXC_ERET = 32'h0000_000e
    } exc_type_e;

    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned CAUSE_BD   = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] ZERO_WORD    = '0;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: tick divider, free-running Count and sticky compare-match interrupt.
module cp0_timer
    import cp0_reg_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;
    logic inc;
    logic wr_count;
    logic wr_compare;

    assign inc        = (COUNT_DIV == 1) || tick;
    assign wr_count   = we && (waddr == CP0_COUNT);
    assign wr_compare = we && (waddr == CP0_COMPARE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick      <= 1'b0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;
            if (wr_count)
                count <= data;
            else if (inc)
                count <= count + 32'd1;
            if (wr_compare)
                compare <= data;
            // A Compare write acknowledges the interrupt even on a coincident match.
            if (wr_compare)
                timer_int <= 1'b0;
            else if ((compare != ZERO_WORD) && (count == compare))
                timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file (MEM stage): exception/ERET state updates, mtc0/mfc0, timer.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] status_nxt;
    logic [31:0] cause_nxt;
    logic [31:0] epc_nxt;
    logic [31:0] badvaddr_nxt;
    logic        is_exc;
    logic        is_eret;
    logic        wr_en;

    assign is_eret = (except_type_i == EXC_ERET);
    assign is_exc  = (except_type_i != EXC_NONE) && !is_eret;
    assign wr_en   = we_i && (except_type_i == EXC_NONE);

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en),
        .waddr     (waddr_i),
        .data      (data_i),
        .count     (count_o),
        .compare   (compare_o),
        .timer_int (timer_int_o)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = (COUNT_DIV == 2);
    assign count_o     = '0;
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
`endif

    always_comb begin
        status_nxt   = status_o;
        cause_nxt    = cause_o;
        epc_nxt      = epc_o;
        badvaddr_nxt = badvaddr_o;
        cause_nxt[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
        if (is_exc) begin
            if (!status_o[STATUS_EXL]) begin
                epc_nxt             = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_nxt[CAUSE_BD] = is_in_delayslot_i;
            end
            status_nxt[STATUS_EXL] = 1'b1;
            cause_nxt[6:2]         = except_type_i[4:0];
            if ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES))
                badvaddr_nxt = badvaddr_i;
        end else if (is_eret) begin
            status_nxt[STATUS_EXL] = 1'b0;
        end else if (wr_en) begin
            case (waddr_i)
                CP0_STATUS: status_nxt = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                CP0_CAUSE:  cause_nxt[9:8] = data_i[9:8];
                CP0_EPC:    epc_nxt = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_o   <= RESET_STATUS;
            cause_o    <= '0;
            epc_o      <= '0;
            badvaddr_o <= '0;
        end else begin
            status_o   <= status_nxt;
            cause_o    <= cause_nxt;
            epc_o      <= epc_nxt;
            badvaddr_o <= badvaddr_nxt;
        end
    end

    always_comb begin
        data_o = ZERO_WORD;
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_o;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_o;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_o;
            default:      data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed self-checking bench for cp0_reg; timer checks follow CP0_TIMER_EN.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] except_type_i = '0;
    logic [31:0] pc_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] badvaddr_i = '0;
    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    cp0_reg #(.RESET_STATUS(32'h0040_0000), .COUNT_DIV(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .raddr_i           (raddr_i),
        .data_i            (data_i),
        .int_i             (int_i),
        .except_type_i     (except_type_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .badvaddr_i        (badvaddr_i),
        .data_o            (data_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .badvaddr_o        (badvaddr_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .timer_int_o       (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
        we_i = 1'b1; waddr_i = addr; data_i = val;
        step();
        we_i = 1'b0;
    endtask

    initial begin
        int unsigned wait_n;
        logic        got_int;

        step();
        step();
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_badvaddr", badvaddr_o, 32'h0);
        check("rst_count", count_o, 32'h0);
        check("rst_timer", {31'b0, timer_int_o}, 32'h0);
        rst = 1'b1;
        step();

        // Overflow in a delay slot with EXL clear
        except_type_i = 32'hc; pc_i = 32'hbfc0_0104; is_in_delayslot_i = 1'b1;
        step();
        check("ds_epc", epc_o, 32'hbfc0_0100);
        check("ds_bd", {31'b0, cause_o[31]}, 32'h1);
        check("ds_exccode", {27'b0, cause_o[6:2]}, 32'h0c);
        check("ds_exl", {31'b0, status_o[1]}, 32'h1);

        // Nested syscall keeps EPC/BD
        except_type_i = 32'h8; pc_i = 32'h1234_5678; is_in_delayslot_i = 1'b0;
        step();
        check("nest_epc", epc_o, 32'hbfc0_0100);
        check("nest_exccode", {27'b0, cause_o[6:2]}, 32'h08);
        check("nest_bd", {31'b0, cause_o[31]}, 32'h1);

        except_type_i = 32'he;
        step();
        check("eret_status", status_o, 32'h0040_0000);
        check("eret_epc", epc_o, 32'hbfc0_0100);

        // AdEL with a concurrent mtc0 to EPC
        except_type_i = 32'h4; badvaddr_i = 32'h8000_0003; pc_i = 32'h0040_0010;
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hdead_beef;
        step();
        we_i = 1'b0; except_type_i = 32'h0;
        check("adel_badvaddr", badvaddr_o, 32'h8000_0003);
        check("adel_epc", epc_o, 32'h0040_0010);
        check("adel_cause", cause_o, 32'h0000_0010);
        except_type_i = 32'he;
        step();
        except_type_i = 32'h0;
        check("adel_eret_status", status_o, 32'h0040_0000);

        raddr_i = 5'd14; #1;
        check("rd_epc", data_o, 32'h0040_0010);
        raddr_i = 5'd8; #1;
        check("rd_badvaddr", data_o, 32'h8000_0003);

        mtc0(5'd12, 32'hffff_ffff);
        check("wmask_status", status_o, 32'h0040_ff03);
        mtc0(5'd13, 32'hffff_ffff);
        check("wmask_cause", cause_o, 32'h0000_0310);
        mtc0(5'd12, 32'h0000_0000);
        check("status_clear", status_o, 32'h0040_0000);
        mtc0(5'd8, 32'h0000_0000);
        check("badvaddr_ro", badvaddr_o, 32'h8000_0003);
        mtc0(5'd3, 32'h1111_1111);
        raddr_i = 5'd3; #1;
        check("rd_unmapped", data_o, 32'h0);

        int_i = 6'b100001;
        step();
        check("hw_int_cause", cause_o, 32'h0000_8710);
        int_i = 6'b000000;
        step();
        check("hw_int_clear", cause_o, 32'h0000_0310);

`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'd100);
        check("count_write", count_o, 32'd100);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        check("compare_write", compare_o, 32'd5);
        got_int = 1'b0;
        wait_n  = 0;
        for (int i = 0; i < 30; i++) begin
            if (!got_int) begin
                step();
                wait_n++;
                if (timer_int_o) got_int = 1'b1;
            end
        end
        check("timer_fired", {31'b0, got_int}, 32'h1);
        check("timer_latency_ok", {31'b0, (wait_n >= 8 && wait_n <= 12)}, 32'h1);
        step();
        check("timer_cause15", {31'b0, cause_o[15]}, 32'h1);
        check("timer_sticky", {31'b0, timer_int_o}, 32'h1);
        mtc0(5'd11, 32'd0);
        check("timer_clear", {31'b0, timer_int_o}, 32'h0);
`else
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd7);
        raddr_i = 5'd9; #1;
        check("rd_count_off", data_o, 32'h0);
        raddr_i = 5'd11; #1;
        check("rd_compare_off", data_o, 32'h0);
        for (int i = 0; i < 12; i++) step();
        check("timer_off", {31'b0, timer_int_o}, 32'h0);
        check("count_off", count_o, 32'h0);
`endif

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        check("async_status", status_o, 32'h0040_0000);
        check("async_epc", epc_o, 32'h0);
        check("async_badvaddr", badvaddr_o, 32'h0);
        check("async_cause", cause_o, 32'h0);
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
